dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: arbitrates a single data-memory port between loads and store-buffer
// retirement. Loads win by default, but a committed store gets priority once the
// buffer is full or after ST_STARVE_MAX consecutive loads have gone ahead of it.
// Loads that hit in the store buffer are answered by forwarding, without touching memory.

`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

module dmem_arb #(
  parameter int ST_STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_ld_req,
  input  logic [`RV32_ADDR_WIDTH-1:0] i_ld_addr,
  input  logic                        i_stbuf_addr_hit,
  input  logic [`RV32_DATA_WIDTH-1:0] i_stbuf_rd_data,
  input  logic                        i_stbuf_pend,
  input  logic                        i_stbuf_full,
  output logic                        o_dmem_occupy,
  input  logic                        i_ret_stbuf,
  input  logic [`RV32_ADDR_WIDTH-1:0] i_ret_stbuf_addr,
  input  logic [`RV32_DATA_WIDTH-1:0] i_ret_stbuf_data,
  output logic                        o_ld_ack,
  output logic                        o_ld_rvalid,
  output logic [`RV32_DATA_WIDTH-1:0] o_ld_rdata,
  output logic                        o_dmem_req,
  output logic                        o_dmem_we,
  output logic [`RV32_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [`RV32_DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic                        i_dmem_gnt,
  input  logic                        i_dmem_rvalid,
  input  logic [`RV32_DATA_WIDTH-1:0] i_dmem_rdata
);

  // A zero limit still needs a one-bit counter so the compare stays legal.
  localparam int CNT_W = (ST_STARVE_MAX < 1) ? 1 : $clog2(ST_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ST_STARVE_MAX);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_REQ  = 2'd1;
  localparam logic [1:0] LD_RESP = 2'd2;
  localparam logic [1:0] ST_REQ  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             st_prio;
  logic             ld_accept;
  logic             st_accept;

  // Stores take priority when the buffer is full or loads have starved them long enough.
  assign st_prio = i_stbuf_full | (i_stbuf_pend & (starve_cnt == CNT_MAX));

  // Occupy is asserted whenever the port is busy or a load is about to claim it, so the
  // store buffer only retires into a cycle that is guaranteed to be accepted.
  assign o_dmem_occupy = ~rst & ((state != IDLE) | (i_ld_req & ~st_prio));

  assign ld_accept = ~rst & (state == IDLE) & i_ld_req & ~st_prio;
  assign st_accept = (state == IDLE) & ~o_dmem_occupy & i_ret_stbuf;
  assign o_ld_ack  = ld_accept;

  assign o_dmem_req = (state == LD_REQ) | (state == ST_REQ);
  assign o_dmem_we  = (state == ST_REQ);

  // Next-state decode; memory handshakes are only honoured in the states that expect them.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ld_accept && !i_stbuf_addr_hit) begin
          state_nxt = LD_REQ;
        end else if (st_accept) begin
          state_nxt = ST_REQ;
        end
      end
      LD_REQ: begin
        if (i_dmem_gnt) state_nxt = LD_RESP;
      end
      LD_RESP: begin
        if (i_dmem_rvalid) state_nxt = IDLE;
      end
      ST_REQ: begin
        if (i_dmem_gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and the starvation counter that lets pending stores eventually win.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (st_accept || !i_stbuf_pend) begin
        starve_cnt <= '0;
      end else if (ld_accept && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Load result: forwarded data or memory read data, presented as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ld_rvalid <= 1'b0;
      o_ld_rdata  <= '0;
    end else begin
      o_ld_rvalid <= 1'b0;
      if (ld_accept && i_stbuf_addr_hit) begin
        o_ld_rvalid <= 1'b1;
        o_ld_rdata  <= i_stbuf_rd_data;
      end else if (state == LD_RESP && i_dmem_rvalid) begin
        o_ld_rvalid <= 1'b1;
        o_ld_rdata  <= i_dmem_rdata;
      end
    end
  end

  // Request address/data are captured when a transaction starts and held until it ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
    end else if (ld_accept && !i_stbuf_addr_hit) begin
      o_dmem_addr <= i_ld_addr;
    end else if (st_accept) begin
      o_dmem_addr  <= i_ret_stbuf_addr;
      o_dmem_wdata <= i_ret_stbuf_data;
    end
  end

endmodule
